// File: rtl/spi_flash_read_arbiter_if.sv
// Requester and flash-controller facing signals of spi_flash_read_arbiter.
// slave = arbiter side, master = requesters plus flash controller (or a bench standing in for them).
interface spi_flash_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
) ();
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned BRAM_AW   = 10;
  localparam int unsigned BRAM_DW   = 8;

  // requester side
  logic [NUM_REQ-1:0]        i_req;
  logic [ADDR_W*NUM_REQ-1:0] i_req_addr;
  logic [NUM_REQ-1:0]        o_grant;
  logic [NUM_REQ-1:0]        o_done_stb;
  logic                      o_timeout_stb;
  logic                      o_busy;

  // flash controller side
  logic [ADDR_W-1:0]         o_read_addr;
  logic                      o_read_stb;
  logic                      i_read_done_stb;
  logic                      i_write_bram_stb;
  logic [BRAM_AW-1:0]        i_write_bram_addr;
  logic [BRAM_DW-1:0]        i_write_bram_data;

  // BRAM write fan-out
  logic [NUM_REQ-1:0]        o_write_bram_stb;
  logic [BRAM_AW-1:0]        o_write_bram_addr;
  logic [BRAM_DW-1:0]        o_write_bram_data;

  modport slave (
    input  i_req,
    input  i_req_addr,
    output o_grant,
    output o_done_stb,
    output o_timeout_stb,
    output o_busy,
    output o_read_addr,
    output o_read_stb,
    input  i_read_done_stb,
    input  i_write_bram_stb,
    input  i_write_bram_addr,
    input  i_write_bram_data,
    output o_write_bram_stb,
    output o_write_bram_addr,
    output o_write_bram_data
  );

  modport master (
    output i_req,
    output i_req_addr,
    input  o_grant,
    input  o_done_stb,
    input  o_timeout_stb,
    input  o_busy,
    input  o_read_addr,
    input  o_read_stb,
    output i_read_done_stb,
    output i_write_bram_stb,
    output i_write_bram_addr,
    output i_write_bram_data,
    input  o_write_bram_stb,
    input  o_write_bram_addr,
    input  o_write_bram_data
  );
endinterface

// File: rtl/spi_flash_read_arbiter.sv
// Round-robin arbiter sharing one spi_flash_ctrl block-read engine between NUM_REQ requesters.
// Optional WAIT-state abort counter enabled by defining SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_read_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  spi_flash_read_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned BRAM_AW = 10;
  localparam int unsigned BRAM_DW = 8;
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;

  // Round-robin search starting one past the last served requester
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!pick_valid && bus.i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (pick_idx == IDX_W'(r)) begin
        sel_addr = bus.i_req_addr[ADDR_W*r +: ADDR_W];
      end
    end
  end

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  logic [23:0] wait_cnt;
`else
  // No abort path: the read is only ever ended by the flash controller's done.
  assign bus.o_timeout_stb = 1'b0 && (TIMEOUT_CYCLES != 24'd0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                 <= S_IDLE;
      last_grant            <= IDX_W'(NUM_REQ - 1);
      cur_idx               <= '0;
      bus.o_grant           <= '0;
      bus.o_done_stb        <= '0;
      bus.o_busy            <= 1'b0;
      bus.o_read_addr       <= '0;
      bus.o_read_stb        <= 1'b0;
      bus.o_write_bram_stb  <= '0;
      bus.o_write_bram_addr <= '0;
      bus.o_write_bram_data <= '0;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      bus.o_timeout_stb     <= 1'b0;
      wait_cnt              <= '0;
`endif
    end else begin
      bus.o_read_stb       <= 1'b0;
      bus.o_done_stb       <= '0;
      bus.o_write_bram_stb <= '0;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      bus.o_timeout_stb    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            cur_idx         <= pick_idx;
            bus.o_read_addr <= sel_addr;
            bus.o_grant     <= NUM_REQ'(1) << pick_idx;
            bus.o_busy      <= 1'b1;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          bus.o_read_stb <= 1'b1;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
          wait_cnt       <= '0;
`endif
          state          <= S_WAIT;
        end

        S_WAIT: begin
          // Writes are forwarded even on the done cycle so none are lost
          if (bus.i_write_bram_stb) begin
            bus.o_write_bram_stb  <= bus.o_grant;
            bus.o_write_bram_addr <= bus.i_write_bram_addr;
            bus.o_write_bram_data <= bus.i_write_bram_data;
          end
          if (bus.i_read_done_stb) begin
            bus.o_done_stb <= bus.o_grant;
            bus.o_grant    <= '0;
            state          <= S_RELEASE;
          end
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_CYCLES - 24'd1) begin
            bus.o_timeout_stb <= 1'b1;
            bus.o_done_stb    <= bus.o_grant;
            bus.o_grant       <= '0;
            state             <= S_RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
`endif
        end

        S_RELEASE: begin
          last_grant <= cur_idx;
          bus.o_busy <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          bus.o_grant <= '0;
          bus.o_busy  <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, BRAM_AW[0], BRAM_DW[0]};

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Self-checking bench for spi_flash_read_arbiter: vector table, hand sequences and randomized
// transactions checked against a round-robin reference model.
module tb_spi_flash_read_arbiter;
  localparam int NREQ = 2;

  logic clk;
  logic rst;

  spi_flash_read_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  spi_flash_read_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_last = NREQ - 1;

  // Output strobe counters, sampled away from the active edge
  int wr_cnt [NREQ];
  int done_cnt [NREQ];
  int to_cnt = 0;
  initial begin
    for (int r = 0; r < NREQ; r++) begin
      wr_cnt[r]   = 0;
      done_cnt[r] = 0;
    end
  end
  always @(negedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (bus.o_write_bram_stb[r]) wr_cnt[r]++;
      if (bus.o_done_stb[r]) done_cnt[r]++;
    end
    if (bus.o_timeout_stb) to_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks bad", n_err, n_vec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting index after the last winner, wrapping
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   32'(bus.o_grant), 32'd0);
    chk({tag, "_done"},    32'(bus.o_done_stb), 32'd0);
    chk({tag, "_busy"},    32'(bus.o_busy), 32'd0);
    chk({tag, "_rdstb"},   32'(bus.o_read_stb), 32'd0);
    chk({tag, "_rdaddr"},  32'(bus.o_read_addr), 32'd0);
    chk({tag, "_wrstb"},   32'(bus.o_write_bram_stb), 32'd0);
    chk({tag, "_wraddr"},  32'(bus.o_write_bram_addr), 32'd0);
    chk({tag, "_wrdata"},  32'(bus.o_write_bram_data), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout_stb), 32'd0);
  endtask

  // One full block read: request from idle, n_wr BRAM writes, done.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int n_wr, input bit drop,
                         input int exp_idx, input string tag);
    logic [NREQ-1:0] g;
    logic [23:0]     exp_addr;
    logic [9:0]      wa;
    logic [7:0]      wd;
    int              wr0 [NREQ];
    int              dn0 [NREQ];
    g        = NREQ'(1) << exp_idx;
    exp_addr = bus.i_req_addr[24*exp_idx +: 24];
    for (int r = 0; r < NREQ; r++) begin
      wr0[r] = wr_cnt[r];
      dn0[r] = done_cnt[r];
    end
    bus.i_req = mask;
    tick();
    chk({tag, "_grant"}, 32'(bus.o_grant), 32'(g));
    chk({tag, "_busy"},  32'(bus.o_busy), 32'd1);
    chk({tag, "_rdstb_early"}, 32'(bus.o_read_stb), 32'd0);
    tick();
    chk({tag, "_rdstb"},  32'(bus.o_read_stb), 32'd1);
    chk({tag, "_rdaddr"}, 32'(bus.o_read_addr), 32'(exp_addr));
    if (drop) bus.i_req = mask & ~g;
    for (int i = 0; i < n_wr; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) tick();
      wa = 10'($urandom);
      wd = 8'($urandom);
      bus.i_write_bram_stb  = 1'b1;
      bus.i_write_bram_addr = wa;
      bus.i_write_bram_data = wd;
      if ($urandom_range(0, 3) == 0) bus.i_req_addr = {24'($urandom), 24'($urandom)};
      tick();
      bus.i_write_bram_stb = 1'b0;
      chk({tag, "_wrstb"},  32'(bus.o_write_bram_stb), 32'(g));
      chk({tag, "_wraddr"}, 32'(bus.o_write_bram_addr), 32'(wa));
      chk({tag, "_wrdata"}, 32'(bus.o_write_bram_data), 32'(wd));
    end
    tick();
    bus.i_read_done_stb = 1'b1;
    tick();
    bus.i_read_done_stb = 1'b0;
    chk({tag, "_done"},       32'(bus.o_done_stb), 32'(g));
    chk({tag, "_grant_rel"},  32'(bus.o_grant), 32'd0);
    chk({tag, "_busy_rel"},   32'(bus.o_busy), 32'd1);
    chk({tag, "_rdaddr_hold"}, 32'(bus.o_read_addr), 32'(exp_addr));
    bus.i_req = bus.i_req & ~g;
    tick();
    chk({tag, "_busy_idle"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done_once"}, 32'(bus.o_done_stb), 32'd0);
    for (int r = 0; r < NREQ; r++) begin
      chk({tag, "_wr_count"},   32'(wr_cnt[r] - wr0[r]),   (r == exp_idx) ? 32'(n_wr) : 32'd0);
      chk({tag, "_done_count"}, 32'(done_cnt[r] - dn0[r]), (r == exp_idx) ? 32'd1 : 32'd0);
    end
    model_last = exp_idx;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              n_wr;
    bit              drop;
    int              exp_idx;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{req: 2'b11, n_wr: 4, drop: 1'b0, exp_idx: 0}; // both after reset: r0 first
    tbl[1] = '{req: 2'b11, n_wr: 3, drop: 1'b0, exp_idx: 1}; // then r1
    tbl[2] = '{req: 2'b11, n_wr: 2, drop: 1'b0, exp_idx: 0}; // r0 re-request: r0,r1,r0
    tbl[3] = '{req: 2'b11, n_wr: 1, drop: 1'b1, exp_idx: 1}; // r1 drops mid-read
    tbl[4] = '{req: 2'b01, n_wr: 0, drop: 1'b0, exp_idx: 0}; // pending r0 next
    tbl[5] = '{req: 2'b01, n_wr: 2, drop: 1'b0, exp_idx: 0}; // lone requester re-served
    tbl[6] = '{req: 2'b10, n_wr: 1, drop: 1'b0, exp_idx: 1};
    tbl[7] = '{req: 2'b11, n_wr: 1, drop: 1'b0, exp_idx: 0};

    rst                   = 1'b1;
    bus.i_req             = '0;
    bus.i_req_addr        = {24'h020000, 24'h010000};
    bus.i_read_done_stb   = 1'b0;
    bus.i_write_bram_stb  = 1'b0;
    bus.i_write_bram_addr = '0;
    bus.i_write_bram_data = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      bus.i_req_addr = {24'h020000 + 24'(i), 24'h010000 + 24'(i)};
      chk("tbl_model", 32'(rr_pick(model_last, tbl[i].req)), 32'(tbl[i].exp_idx));
      run_txn(tbl[i].req, tbl[i].n_wr, tbl[i].drop, tbl[i].exp_idx, $sformatf("tbl%0d", i));
    end

    // Full 512-byte block to r0 at 0x010000
    bus.i_req_addr = {24'h020000, 24'h010000};
    run_txn(2'b01, 512, 1'b0, 0, "blk512");

    // Stray controller strobes while idle
    bus.i_req             = '0;
    bus.i_write_bram_stb  = 1'b1;
    bus.i_read_done_stb   = 1'b1;
    bus.i_write_bram_addr = 10'h155;
    bus.i_write_bram_data = 8'hA5;
    tick();
    bus.i_write_bram_stb = 1'b0;
    bus.i_read_done_stb  = 1'b0;
    chk("stray_wrstb", 32'(bus.o_write_bram_stb), 32'd0);
    chk("stray_done",  32'(bus.o_done_stb), 32'd0);
    chk("stray_busy",  32'(bus.o_busy), 32'd0);
    tick();
    chk("stray_busy2", 32'(bus.o_busy), 32'd0);
    chk("stray_grant", 32'(bus.o_grant), 32'd0);

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, 3));
      bus.i_req_addr = {24'($urandom), 24'($urandom)};
      run_txn(m, $urandom_range(0, 6), ($urandom_range(0, 3) == 0), rr_pick(model_last, m),
              $sformatf("rnd%0d", t));
    end

    // Reset in the middle of a read
    bus.i_req = 2'b10;
    tick();
    tick();
    bus.i_write_bram_stb = 1'b1;
    tick();
    bus.i_write_bram_stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(bus.o_grant), 32'd0);
    chk("midrst_busy",  32'(bus.o_busy), 32'd0);
    chk("midrst_wrstb", 32'(bus.o_write_bram_stb), 32'd0);
    chk("midrst_rdaddr", 32'(bus.o_read_addr), 32'd0);
    tick();
    rst = 1'b0;
    bus.i_req = '0;
    tick();
    chk("midrst_idle", 32'(bus.o_busy), 32'd0);
    model_last = NREQ - 1;
    bus.i_req_addr = {24'h020000, 24'h010000};
    run_txn(2'b11, 2, 1'b0, 0, "post_midrst");

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    begin
      int w;
      int seen;
      int to0;
      to0  = to_cnt;
      seen = -1;
      bus.i_req = 2'b01;
      tick();
      tick();
      chk("to_rdstb", 32'(bus.o_read_stb), 32'd1);
      for (w = 1; w <= 300 && seen < 0; w++) begin
        tick();
        if (bus.o_timeout_stb) begin
          seen = w;
          chk("to_done_same_cycle", 32'(bus.o_done_stb), 32'b01);
        end
      end
      bus.i_req = '0;
      chk("to_cycle", 32'(seen), 32'd100);
      tick();
      chk("to_idle", 32'(bus.o_busy), 32'd0);
      chk("to_count", 32'(to_cnt - to0), 32'd1);
      model_last = 0;
    end
`else
    begin
      int to0;
      to0 = to_cnt;
      bus.i_req = 2'b01;
      tick();
      tick();
      chk("nto_rdstb", 32'(bus.o_read_stb), 32'd1);
      repeat (10000) tick();
      chk("nto_busy",    32'(bus.o_busy), 32'd1);
      chk("nto_grant",   32'(bus.o_grant), 32'b01);
      chk("nto_timeout", 32'(to_cnt - to0), 32'd0);
      bus.i_read_done_stb = 1'b1;
      tick();
      bus.i_read_done_stb = 1'b0;
      chk("nto_done", 32'(bus.o_done_stb), 32'b01);
      bus.i_req = '0;
      tick();
      chk("nto_idle", 32'(bus.o_busy), 32'd0);
      model_last = 0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
